seg_scan_ctrl: RTL and testbench

- Memory-mapped controller that owns the 4-digit seven-segment display for the hCPU system.
- Captures CPU writes (writeM/addressM/outM) to two registers, DATA and CTRL, and provides registered readback for inM.
- Time-multiplexes the four digits. Each digit is preceded by a blanking interval to suppress ghosting.
- Display content updates only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_scan_ctrl_segcom.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encodings,
// CTRL register layout and the default blank pattern.
package seg_pkg;

    // Scan FSM states.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    // CTRL register layout.
    localparam int          CTRL_EN       = 0;
    localparam int          CTRL_MASK_LSB = 4;
    localparam logic [15:0] CTRL_WMASK    = 16'h00F1;
    localparam logic [15:0] CTRL_RESET    = 16'h00F1;

    // Segments are active-low, so all-ones turns every segment off.
    localparam logic [7:0]  BLANK_PATTERN_DEFAULT = 8'hFF;

    // Active-low digit select for one of the four digits; upper nibble unused.
    function automatic logic [7:0] digit_sel(input logic [1:0] digit);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << digit;
        return {4'hF, ~one_hot};
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_segcom.sv
// segcom: hex nibble to active-low seven-segment pattern {dp,g,f,e,d,c,b,a}.
// The decimal point is always off.
module segcom (
    input  logic [3:0] hex_i,
    output logic [7:0] seg_o
);

    // Pure lookup from nibble to segment pattern.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path (default branch here), otherwise a latch is inferred.
        case (hex_i)
            4'h0:    seg_o = 8'hC0;
            4'h1:    seg_o = 8'hF9;
            4'h2:    seg_o = 8'hA4;
            4'h3:    seg_o = 8'hB0;
            4'h4:    seg_o = 8'h99;
            4'h5:    seg_o = 8'h92;
            4'h6:    seg_o = 8'h82;
            4'h7:    seg_o = 8'hF8;
            4'h8:    seg_o = 8'h80;
            4'h9:    seg_o = 8'h90;
            4'hA:    seg_o = 8'h88;
            4'hB:    seg_o = 8'h83;
            4'hC:    seg_o = 8'hC6;
            4'hD:    seg_o = 8'hA1;
            4'hE:    seg_o = 8'h86;
            default: seg_o = 8'h8E;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: memory-mapped 4-digit seven-segment scan controller.
// DATA (BASE_ADDR) holds four hex nibbles in a shadow register that is copied
// to the display register only at frame boundaries; CTRL (BASE_ADDR+1) holds
// the enable bit and a per-digit mask. Each digit is a BLANK interval followed
// by a SHOW interval. All outputs are registered and computed from next state,
// so sel/data always line up with the FSM state of the same cycle.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR     = 16'h4000,
    parameter int          BLANK_CYCLES  = 16,
    parameter int          DWELL_CYCLES  = 1024,
    parameter logic [7:0]  BLANK_PATTERN = BLANK_PATTERN_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [7:0]  sel,
    output logic [7:0]  data,
    output logic        frame_done
);

    localparam int MAX_CYCLES = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [1:0]         digit_q, digit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        shadow_q, shadow_d;
    logic [15:0]        ctrl_q, ctrl_d;
    logic [15:0]        disp_q, disp_d;
    logic [15:0]        rdata_q, rdata_d;
    logic [7:0]         sel_q, sel_d;
    logic [7:0]         data_q, data_d;
    logic               frame_done_q, frame_done_d;

    logic               data_wr, ctrl_wr;
    logic               en_d;
    logic [3:0]         mask_d;
    logic [3:0]         nibble;
    logic [7:0]         seg_pat;

    // Register file: address decode, DATA/CTRL writes and pre-write readback.
    always_comb begin
        data_wr  = wr_en && (addr == BASE_ADDR);
        ctrl_wr  = wr_en && (addr == BASE_ADDR + 16'd1);
        shadow_d = shadow_q;
        ctrl_d   = ctrl_q;
        if (data_wr) shadow_d = wdata;
        if (ctrl_wr) ctrl_d = wdata & CTRL_WMASK;
        if (addr == BASE_ADDR)              rdata_d = shadow_q;
        else if (addr == BASE_ADDR + 16'd1) rdata_d = ctrl_q;
        else                                rdata_d = 16'h0000;
        en_d   = ctrl_d[CTRL_EN];
        mask_d = ctrl_d[CTRL_MASK_LSB +: 4];
    end

    // Scan FSM: OFF -> BLANK -> SHOW per digit, frame boundary after digit 3.
    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        cnt_d        = cnt_q + 1'b1;
        disp_d       = disp_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (data_wr) disp_d = wdata;
                if (en_d) begin
                    state_d = ST_BLANK;
                    digit_d = 2'd0;
                end
            end
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                    state_d = ST_BLANK;
                    digit_d = digit_q + 2'd1;
                    if (digit_q == 2'd3) begin
                        // shadow_d already carries a same-cycle DATA write.
                        disp_d       = shadow_d;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase
        // Disabling wins over everything else and leaves disp untouched.
        if (!en_d) begin
            state_d      = ST_OFF;
            digit_d      = 2'd0;
            frame_done_d = 1'b0;
            if (state_q != ST_OFF) disp_d = disp_q;
        end
        if (state_d != state_q) cnt_d = '0;
    end

    // Nibble select for the digit that will be on the outputs next cycle.
    always_comb begin
        case (digit_d)
            2'd0:    nibble = disp_q[3:0];
            2'd1:    nibble = disp_q[7:4];
            2'd2:    nibble = disp_q[11:8];
            default: nibble = disp_q[15:12];
        endcase
    end

    segcom u_segcom (
        .hex_i (nibble),
        .seg_o (seg_pat)
    );

    // Output pattern: light a digit only in SHOW and only if it is unmasked.
    always_comb begin
        sel_d  = 8'hFF;
        data_d = BLANK_PATTERN;
        if (state_d == ST_SHOW && mask_d[digit_d]) begin
            sel_d  = digit_sel(digit_d);
            data_d = seg_pat;
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_OFF;
            digit_q      <= 2'd0;
            cnt_q        <= '0;
            shadow_q     <= 16'h0000;
            ctrl_q       <= CTRL_RESET;
            disp_q       <= 16'h0000;
            rdata_q      <= 16'h0000;
            sel_q        <= 8'hFF;
            data_q       <= BLANK_PATTERN;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            ctrl_q       <= ctrl_d;
            disp_q       <= disp_d;
            rdata_q      <= rdata_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rdata      = rdata_q;
    assign sel        = sel_q;
    assign data       = data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with BLANK_CYCLES=2, DWELL_CYCLES=4.
// One frame is 24 cycles. Step k counts clock edges since scanning (re)started
// from BLANK of digit 0; k=1 is the edge that leaves OFF or reset.
module tb_seg_scan_ctrl;

    localparam logic [15:0] A_DATA = 16'h4000;
    localparam logic [15:0] A_CTRL = 16'h4001;
    localparam logic [15:0] A_NONE = 16'h4002;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for hex 0..F.
    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [7:0]  sel;
    logic [7:0]  data;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    seg_scan_ctrl #(
        .BASE_ADDR     (16'h4000),
        .BLANK_CYCLES  (2),
        .DWELL_CYCLES  (4),
        .BLANK_PATTERN (8'hFF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .sel        (sel),
        .data       (data),
        .frame_done (frame_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs at step k of a frame, from the frame timeline.
    task automatic check_state(input int k, input logic [15:0] dv, input logic [3:0] m);
        int         pos, d, r;
        logic       lit;
        logic [3:0] oh, nib;
        logic [7:0] es, ed;
        logic       efd;
        pos = (k - 1) % 24;
        d   = pos / 6;
        r   = pos % 6;
        lit = (r >= 2) && m[d];
        oh  = 4'b0001 << d;
        nib = dv[4*d +: 4];
        es  = lit ? {4'hF, ~oh} : 8'hFF;
        ed  = lit ? SEG_TAB[nib] : 8'hFF;
        efd = (k > 1) && (pos == 0);
        check($sformatf("sel k=%0d", k), {8'h00, sel}, {8'h00, es});
        check($sformatf("data k=%0d", k), {8'h00, data}, {8'h00, ed});
        check($sformatf("frame_done k=%0d", k), {15'h0, frame_done}, {15'h0, efd});
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr_en = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;
        tick();
        tick();

        // Reset state.
        check("reset sel", {8'h00, sel}, 16'h00FF);
        check("reset data", {8'h00, data}, 16'h00FF);
        check("reset rdata", rdata, 16'h0000);
        check("reset frame_done", {15'h0, frame_done}, 16'h0000);

        // Two full frames straight out of reset (enabled, all digits, disp=0).
        reset = 1'b0;
        for (int k = 1; k <= 49; k++) begin
            tick();
            check_state(k, 16'h0000, 4'hF);
        end

        // Disable, load DATA while OFF, check readback latency, re-enable.
        wr(A_CTRL, 16'h0000);
        check("off sel", {8'h00, sel}, 16'h00FF);
        check("off frame_done", {15'h0, frame_done}, 16'h0000);
        wr(A_DATA, 16'h1234);
        check("rdata pre-write", rdata, 16'h0000);
        check("off sel after data", {8'h00, sel}, 16'h00FF);
        addr = A_DATA;
        tick();
        check("rdata data", rdata, 16'h1234);
        addr = 16'h0000;
        wr(A_CTRL, 16'h00F1);
        check_state(1, 16'h1234, 4'hF);
        for (int k = 2; k <= 32; k++) begin
            tick();
            check_state(k, 16'h1234, 4'hF);
        end

        // DATA write during digit 1: current frame keeps old value.
        wr(A_DATA, 16'hABCD);
        check_state(33, 16'h1234, 4'hF);
        for (int k = 34; k <= 48; k++) begin
            tick();
            check_state(k, 16'h1234, 4'hF);
        end
        for (int k = 49; k <= 72; k++) begin
            tick();
            check_state(k, 16'hABCD, 4'hF);
        end

        // DATA write in the frame-boundary cycle: the write wins.
        wr(A_DATA, 16'h5678);
        check_state(73, 16'h5678, 4'hF);
        for (int k = 74; k <= 96; k++) begin
            tick();
            check_state(k, 16'h5678, 4'hF);
        end

        // Mask 0101: digits 1 and 3 dark for their full dwell, period unchanged.
        wr(A_CTRL, 16'h0051);
        check_state(97, 16'h5678, 4'b0101);
        for (int k = 98; k <= 121; k++) begin
            tick();
            check_state(k, 16'h5678, 4'b0101);
        end
        addr = A_CTRL;
        tick();
        check_state(122, 16'h5678, 4'b0101);
        check("rdata ctrl", rdata, 16'h0051);
        tick();
        check_state(123, 16'h5678, 4'b0101);
        tick();
        check_state(124, 16'h5678, 4'b0101);

        // Mid-SHOW disable.
        wr(A_CTRL, 16'h0000);
        check("disable sel", {8'h00, sel}, 16'h00FF);
        check("disable data", {8'h00, data}, 16'h00FF);
        check("disable frame_done", {15'h0, frame_done}, 16'h0000);
        check("rdata ctrl pre-write", rdata, 16'h0051);
        addr = A_CTRL;
        tick();
        check("rdata ctrl cleared", rdata, 16'h0000);
        addr = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            tick();
            check($sformatf("disabled sel i=%0d", i), {8'h00, sel}, 16'h00FF);
            check($sformatf("disabled frame_done i=%0d", i), {15'h0, frame_done}, 16'h0000);
        end

        // Write to an unmapped address changes nothing.
        wr(A_NONE, 16'hFFFF);
        check("unmapped sel", {8'h00, sel}, 16'h00FF);
        addr = A_DATA;
        tick();
        check("unmapped data reg", rdata, 16'h5678);
        addr = A_CTRL;
        tick();
        check("unmapped ctrl reg", rdata, 16'h0000);
        addr = A_NONE;
        tick();
        check("unmapped readback", rdata, 16'h0000);
        addr = 16'h0000;

        // Re-enable, then assert reset mid-frame: scanning restarts at BLANK of digit 0.
        wr(A_CTRL, 16'h00F1);
        check_state(1, 16'h5678, 4'hF);
        for (int k = 2; k <= 10; k++) begin
            tick();
            check_state(k, 16'h5678, 4'hF);
        end
        #2;
        reset = 1'b1;
        #1;
        check("async reset sel", {8'h00, sel}, 16'h00FF);
        check("async reset data", {8'h00, data}, 16'h00FF);
        check("async reset rdata", rdata, 16'h0000);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_state(k, 16'h0000, 4'hF);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
